// File: rtl/icache_refill_ctrl.sv
// Icache miss-refill engine: fetches BURST sequential words for a missed PC and
// writes them into the 4-group x 8-way icache using per-group round-robin victims.
module icache_refill_ctrl #(
    parameter int PC_W   = 32,
    parameter int INST_W = 32,
    parameter int GROUPS = 4,
    parameter int WAYS   = 8,
    parameter int BURST  = 4,
    parameter int WAY_W  = $clog2(WAYS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_valid_i,
    input  logic [PC_W-1:0]   miss_pc_i,
    output logic              miss_ready_o,
    input  logic              flush_i,
    output logic              mem_req_valid_o,
    output logic [PC_W-1:0]   mem_req_addr_o,
    input  logic              mem_req_ready_i,
    input  logic              mem_resp_valid_i,
    input  logic [INST_W-1:0] mem_resp_data_i,
    input  logic              mem_resp_err_i,
    output logic              we_o,
    output logic [GROUPS-1:0] windex_o,
    output logic [WAY_W-1:0]  waddr_o,
    output logic [PC_W-1:0]   wpcdata_o,
    output logic [INST_W-1:0] winstdata_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);
    localparam int GRP_W = $clog2(GROUPS);
    localparam int K_W   = (BURST > 1) ? $clog2(BURST) : 1;

    // state   | meaning
    // S_IDLE  | ready for a miss
    // S_REQ   | read request presented to memory, waiting for ready
    // S_WAIT  | request accepted, waiting for the response
    // S_DONE  | burst complete, done_o high
    // S_DRAIN | flushed with a request outstanding, discard its response
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_DRAIN} state_t;

    state_t             r_state, w_state_nxt;
    logic [PC_W-1:0]    r_base, w_base_nxt;
    logic [K_W-1:0]     r_k, w_k_nxt;
    logic [WAY_W-1:0]   r_ptr [GROUPS];
    logic               w_write, w_err;
    logic [PC_W-1:0]    w_cur_pc, w_nxt_pc;
    logic [GRP_W-1:0]   w_grp;
    logic               w_unused;

    assign w_unused     = ^miss_pc_i[1:0];
    assign miss_ready_o = (r_state == S_IDLE);
    assign busy_o       = (r_state != S_IDLE);
    assign w_cur_pc     = r_base + (PC_W'(r_k) << 2);
    assign w_nxt_pc     = w_base_nxt + (PC_W'(w_k_nxt) << 2);
    assign w_grp        = w_cur_pc[GRP_W+1:2];

    always_comb begin
        w_state_nxt = r_state;
        w_base_nxt  = r_base;
        w_k_nxt     = r_k;
        w_write     = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (miss_valid_i) begin
                    w_base_nxt  = {miss_pc_i[PC_W-1:2], 2'b00};
                    w_k_nxt     = '0;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                // A request accepted in the flush cycle still owes a response; drain it.
                if (flush_i)
                    w_state_nxt = mem_req_ready_i ? S_DRAIN : S_IDLE;
                else if (mem_req_ready_i)
                    w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // Flush with the response in the same cycle consumes it on the spot.
                if (flush_i) begin
                    w_state_nxt = mem_resp_valid_i ? S_IDLE : S_DRAIN;
                end else if (mem_resp_valid_i) begin
                    if (mem_resp_err_i) begin
                        w_err       = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_write = 1'b1;
                        if (r_k == K_W'(BURST - 1)) begin
                            w_state_nxt = S_DONE;
                        end else begin
                            w_k_nxt     = r_k + K_W'(1);
                            w_state_nxt = S_REQ;
                        end
                    end
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            S_DRAIN: if (mem_resp_valid_i) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_base          <= '0;
            r_k             <= '0;
            mem_req_valid_o <= 1'b0;
            mem_req_addr_o  <= '0;
            we_o            <= 1'b0;
            windex_o        <= '0;
            waddr_o         <= '0;
            wpcdata_o       <= '0;
            winstdata_o     <= '0;
            done_o          <= 1'b0;
            err_o           <= 1'b0;
            for (int i = 0; i < GROUPS; i++) r_ptr[i] <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_base          <= w_base_nxt;
            r_k             <= w_k_nxt;
            mem_req_valid_o <= (w_state_nxt == S_REQ);
            if (w_state_nxt == S_REQ) mem_req_addr_o <= w_nxt_pc;
            we_o            <= w_write;
            done_o          <= (w_state_nxt == S_DONE);
            err_o           <= w_err;
            if (w_write) begin
                windex_o     <= GROUPS'(1) << w_grp;
                waddr_o      <= r_ptr[w_grp];
                wpcdata_o    <= w_cur_pc;
                winstdata_o  <= mem_resp_data_i;
                r_ptr[w_grp] <= (r_ptr[w_grp] == WAY_W'(WAYS - 1)) ? '0 : r_ptr[w_grp] + WAY_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Self-checking bench for icache_refill_ctrl: randomized misses against a
// burst/victim-pointer reference model, plus stall, flush, error and reset scenarios.
module tb_icache_refill_ctrl;
    localparam int PC_W = 32, INST_W = 32, GROUPS = 4, WAYS = 8, BURST = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, miss_valid_i, miss_ready_o, flush_i;
    logic [PC_W-1:0]   miss_pc_i, mem_req_addr_o, wpcdata_o;
    logic              mem_req_valid_o, mem_req_ready_i, mem_resp_valid_i, mem_resp_err_i;
    logic [INST_W-1:0] mem_resp_data_i, winstdata_o;
    logic              we_o, busy_o, done_o, err_o;
    logic [GROUPS-1:0] windex_o;
    logic [2:0]        waddr_o;

    icache_refill_ctrl #(.PC_W(PC_W), .INST_W(INST_W), .GROUPS(GROUPS), .WAYS(WAYS), .BURST(BURST)) dut (
        .clk(clk), .rst_n(rst_n),
        .miss_valid_i(miss_valid_i), .miss_pc_i(miss_pc_i), .miss_ready_o(miss_ready_o),
        .flush_i(flush_i),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_addr_o(mem_req_addr_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_data_i(mem_resp_data_i), .mem_resp_err_i(mem_resp_err_i),
        .we_o(we_o), .windex_o(windex_o), .waddr_o(waddr_o), .wpcdata_o(wpcdata_o), .winstdata_o(winstdata_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    typedef struct packed {
        logic [3:0]  idx;
        logic [2:0]  way;
        logic [31:0] pc;
        logic [31:0] data;
    } wr_t;

    int n_tests = 0, n_fail = 0;

    // reference model state
    int          ptr_m [GROUPS];
    wr_t         exp_wr [$];
    logic [31:0] exp_req [$];
    int          exp_done = 0, exp_err = 0;

    // memory agent configuration and observations
    int          cfg_ready_lat = 0, cfg_resp_lat = 0;
    bit          cfg_err_en = 1'b0;
    logic [31:0] cfg_err_addr = '0;
    bit          agent_busy = 1'b0;
    int          stall_bad = 0, resp_cnt = 0;
    logic [31:0] req_q [$];

    // write/pulse monitor observations
    wr_t wr_q [$];
    int  done_cnt = 0, err_cnt = 0, we_idle_bad = 0, err_busy_bad = 0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5C3_3C5A;
    endfunction

    // One miss: burst of sequential word addresses, stop before the erroring word.
    function automatic void model_miss(input logic [31:0] pc, input int err_word);
        logic [31:0] base, a;
        int g;
        base = {pc[31:2], 2'b00};
        for (int k = 0; k < BURST; k++) begin
            a = base + 32'(4 * k);
            exp_req.push_back(a);
            if (k == err_word) begin
                exp_err++;
                return;
            end
            g = int'(a[3:2]);
            exp_wr.push_back({4'(1 << g), 3'(ptr_m[g]), a, mem_data(a)});
            ptr_m[g] = (ptr_m[g] + 1) % WAYS;
        end
        exp_done++;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (we_o) wr_q.push_back({windex_o, waddr_o, wpcdata_o, winstdata_o});
            if (done_o) done_cnt++;
            if (err_o) err_cnt++;
            if (we_o && miss_ready_o) we_idle_bad++;
            if (err_o && busy_o) err_busy_bad++;
        end
    end

    initial begin : mem_agent
        logic [31:0] a;
        mem_req_ready_i  = 1'b0;
        mem_resp_valid_i = 1'b0;
        mem_resp_err_i   = 1'b0;
        mem_resp_data_i  = '0;
        forever begin
            @(negedge clk);
            while (rst_n && mem_req_valid_o) begin
                agent_busy = 1'b1;
                a = mem_req_addr_o;
                for (int i = 0; i < cfg_ready_lat; i++) begin
                    @(negedge clk);
                    if (rst_n && (mem_req_valid_o !== 1'b1 || mem_req_addr_o !== a)) stall_bad++;
                end
                mem_req_ready_i = 1'b1;
                req_q.push_back(a);
                @(negedge clk);
                mem_req_ready_i = 1'b0;
                repeat (cfg_resp_lat) @(negedge clk);
                mem_resp_valid_i = 1'b1;
                mem_resp_data_i  = mem_data(a);
                mem_resp_err_i   = cfg_err_en && (a == cfg_err_addr);
                resp_cnt++;
                @(negedge clk);
                mem_resp_valid_i = 1'b0;
                mem_resp_err_i   = 1'b0;
                mem_resp_data_i  = $urandom;
                agent_busy = 1'b0;
            end
        end
    end

    task automatic clear_sb();
        wr_q.delete(); req_q.delete(); exp_wr.delete(); exp_req.delete();
        done_cnt = 0; err_cnt = 0; exp_done = 0; exp_err = 0;
        we_idle_bad = 0; err_busy_bad = 0; stall_bad = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; miss_valid_i = 1'b0; flush_i = 1'b0; miss_pc_i = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int g = 0; g < GROUPS; g++) ptr_m[g] = 0;
        @(negedge clk);
    endtask

    // Present one miss when ready, then wait until engine and memory are idle.
    task automatic drive_miss(input logic [31:0] pc, output bit to);
        int c;
        c = 0; to = 1'b0;
        while (!miss_ready_o && c < 500) begin @(negedge clk); c++; end
        miss_valid_i = 1'b1; miss_pc_i = pc;
        @(negedge clk);
        miss_valid_i = 1'b0; miss_pc_i = $urandom;
        c = 0;
        while ((busy_o || agent_busy) && c < 500) begin @(negedge clk); c++; end
        if (c >= 500) to = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [108:0] obs;
        do_reset();
        obs = {miss_ready_o, busy_o, mem_req_valid_o, mem_req_addr_o, we_o, windex_o, waddr_o,
               wpcdata_o, winstdata_o, done_o, err_o};
        n_tests++;
        if (obs !== {1'b1, 108'd0}) begin
            n_fail++; $display("FAIL reset_outputs: got %h want %h", obs, {1'b1, 108'd0});
        end
    endtask

    task automatic test_basic();
        bit to;
        logic [3:0] idx_tbl [4];
        idx_tbl[0] = 4'b0010; idx_tbl[1] = 4'b0100; idx_tbl[2] = 4'b1000; idx_tbl[3] = 4'b0001;
        clear_sb(); cfg_ready_lat = 0; cfg_resp_lat = 0;
        model_miss(32'h1C00_0004, -1);
        drive_miss(32'h1C00_0004, to);
        n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL basic_timeout: busy stuck"); end
        n_tests++;
        if (req_q.size() != 4) begin n_fail++; $display("FAIL basic_req_count: got %0d want 4", req_q.size()); end
        n_tests++;
        if (wr_q.size() != 4) begin n_fail++; $display("FAIL basic_write_count: got %0d want 4", wr_q.size()); end
        for (int i = 0; i < 4 && i < req_q.size(); i++) begin
            n_tests++;
            if (req_q[i] !== exp_req[i]) begin
                n_fail++; $display("FAIL basic_req_addr[%0d]: got %h want %h", i, req_q[i], exp_req[i]);
            end
        end
        for (int i = 0; i < 4 && i < wr_q.size(); i++) begin
            n_tests++;
            if (wr_q[i] !== exp_wr[i] || wr_q[i].idx !== idx_tbl[i] || wr_q[i].way !== 3'd0) begin
                n_fail++; $display("FAIL basic_write[%0d]: got %h want %h", i, wr_q[i], exp_wr[i]);
            end
        end
        n_tests++;
        if (done_cnt != 1 || err_cnt != 0 || we_idle_bad != 0) begin
            n_fail++; $display("FAIL basic_pulses: done %0d err %0d we_idle %0d want 1 0 0", done_cnt, err_cnt, we_idle_bad);
        end
    endtask

    task automatic test_round_robin();
        bit to;
        logic [31:0] pc;
        do_reset();
        for (int m = 0; m < 9; m++) begin
            clear_sb();
            cfg_ready_lat = $urandom_range(0, 2); cfg_resp_lat = $urandom_range(0, 2);
            pc = $urandom;
            model_miss(pc, -1);
            drive_miss(pc, to);
            n_tests++;
            if (to !== 1'b0 || wr_q.size() != BURST) begin
                n_fail++; $display("FAIL rr_count[%0d]: got %0d writes timeout %0d want %0d", m, wr_q.size(), to, BURST);
            end
            for (int i = 0; i < BURST && i < wr_q.size(); i++) begin
                n_tests++;
                if (wr_q[i] !== exp_wr[i] || wr_q[i].way !== 3'(m % WAYS)) begin
                    n_fail++; $display("FAIL rr_write[%0d][%0d]: got %h want %h", m, i, wr_q[i], exp_wr[i]);
                end
            end
        end
    endtask

    task automatic test_stall();
        bit to;
        logic [31:0] pc;
        clear_sb(); cfg_ready_lat = 5; cfg_resp_lat = 1;
        pc = $urandom;
        model_miss(pc, -1);
        drive_miss(pc, to);
        n_tests++;
        if (to !== 1'b0 || stall_bad != 0) begin
            n_fail++; $display("FAIL stall_stable: unstable cycles %0d timeout %0d want 0 0", stall_bad, to);
        end
        n_tests++;
        if (req_q.size() != BURST || wr_q.size() != BURST) begin
            n_fail++; $display("FAIL stall_counts: got req %0d wr %0d want %0d", req_q.size(), wr_q.size(), BURST);
        end
        for (int i = 0; i < BURST && i < wr_q.size(); i++) begin
            n_tests++;
            if (wr_q[i] !== exp_wr[i]) begin
                n_fail++; $display("FAIL stall_write[%0d]: got %h want %h", i, wr_q[i], exp_wr[i]);
            end
        end
        cfg_ready_lat = 0;
    endtask

    task automatic test_flush();
        int c, rc;
        bit to;
        logic [31:0] pc2;
        clear_sb(); cfg_ready_lat = 0; cfg_resp_lat = 3;
        c = 0;
        while (!miss_ready_o && c < 100) begin @(negedge clk); c++; end
        miss_valid_i = 1'b1; miss_pc_i = $urandom;
        @(negedge clk);
        miss_valid_i = 1'b0;
        c = 0;
        while (!(busy_o && !mem_req_valid_o && req_q.size() == 1) && c < 100) begin @(negedge clk); c++; end
        n_tests++; if (c >= 100) begin n_fail++; $display("FAIL flush_reach_wait: timeout"); end
        rc = resp_cnt;
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        pc2 = $urandom;
        miss_valid_i = 1'b1; miss_pc_i = pc2;
        c = 0;
        while (!miss_ready_o && c < 100) begin @(negedge clk); c++; end
        n_tests++;
        if (resp_cnt == rc || c >= 100) begin
            n_fail++; $display("FAIL flush_drain_first: got resp seen %0d want 1 before accept", resp_cnt - rc);
        end
        n_tests++;
        if (wr_q.size() != 0 || done_cnt != 0 || err_cnt != 0) begin
            n_fail++; $display("FAIL flush_silent: got wr %0d done %0d err %0d want 0 0 0", wr_q.size(), done_cnt, err_cnt);
        end
        @(negedge clk);
        miss_valid_i = 1'b0;
        model_miss(pc2, -1);
        c = 0;
        while ((busy_o || agent_busy) && c < 500) begin @(negedge clk); c++; end
        to = (c >= 500);
        @(negedge clk);
        n_tests++;
        if (to || wr_q.size() != BURST || done_cnt != 1) begin
            n_fail++; $display("FAIL flush_next_miss: got wr %0d done %0d timeout %0d want %0d 1 0", wr_q.size(), done_cnt, to, BURST);
        end
        for (int i = 0; i < BURST && i < wr_q.size(); i++) begin
            n_tests++;
            if (wr_q[i] !== exp_wr[i]) begin
                n_fail++; $display("FAIL flush_write[%0d]: got %h want %h", i, wr_q[i], exp_wr[i]);
            end
        end
        cfg_resp_lat = 0;
    endtask

    task automatic test_error();
        bit to;
        logic [31:0] pc;
        clear_sb(); cfg_ready_lat = 0; cfg_resp_lat = 1;
        pc = $urandom;
        cfg_err_en = 1'b1; cfg_err_addr = {pc[31:2], 2'b00} + 32'd4;
        model_miss(pc, 1);
        drive_miss(pc, to);
        cfg_err_en = 1'b0;
        n_tests++;
        if (to || wr_q.size() != 1 || req_q.size() != 2) begin
            n_fail++; $display("FAIL err_counts: got wr %0d req %0d timeout %0d want 1 2 0", wr_q.size(), req_q.size(), to);
        end
        n_tests++;
        if (wr_q.size() > 0 && wr_q[0] !== exp_wr[0]) begin
            n_fail++; $display("FAIL err_first_write: got %h want %h", wr_q[0], exp_wr[0]);
        end
        n_tests++;
        if (err_cnt != 1 || done_cnt != 0 || err_busy_bad != 0) begin
            n_fail++; $display("FAIL err_pulse: got err %0d done %0d busy_at_err %0d want 1 0 0", err_cnt, done_cnt, err_busy_bad);
        end
        // follow-up miss exposes the victim pointers left by the aborted burst
        clear_sb();
        model_miss(pc, -1);
        drive_miss(pc, to);
        for (int i = 0; i < BURST; i++) begin
            n_tests++;
            if (i >= wr_q.size() || wr_q[i] !== exp_wr[i]) begin
                n_fail++; $display("FAIL err_followup[%0d]: got %h want %h", i, (i < wr_q.size()) ? wr_q[i] : '0, exp_wr[i]);
            end
        end
    endtask

    task automatic test_random();
        bit to;
        int ew;
        logic [31:0] pc;
        for (int m = 0; m < 10; m++) begin
            clear_sb();
            cfg_ready_lat = $urandom_range(0, 3); cfg_resp_lat = $urandom_range(0, 3);
            pc = (m == 0) ? 32'hFFFF_FFF6 : $urandom;
            ew = ($urandom_range(0, 4) == 0) ? $urandom_range(0, BURST - 1) : -1;
            cfg_err_en = (ew >= 0);
            cfg_err_addr = {pc[31:2], 2'b00} + 32'(4 * ew);
            model_miss(pc, ew);
            drive_miss(pc, to);
            cfg_err_en = 1'b0;
            n_tests++;
            if (to || wr_q.size() != exp_wr.size() || req_q.size() != exp_req.size()
                || done_cnt != exp_done || err_cnt != exp_err || we_idle_bad != 0 || err_busy_bad != 0) begin
                n_fail++;
                $display("FAIL rand_summary[%0d]: got wr %0d req %0d done %0d err %0d want %0d %0d %0d %0d",
                         m, wr_q.size(), req_q.size(), done_cnt, err_cnt, exp_wr.size(), exp_req.size(), exp_done, exp_err);
            end
            for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++) begin
                n_tests++;
                if (wr_q[i] !== exp_wr[i]) begin
                    n_fail++; $display("FAIL rand_write[%0d][%0d]: got %h want %h", m, i, wr_q[i], exp_wr[i]);
                end
            end
            for (int i = 0; i < exp_req.size() && i < req_q.size(); i++) begin
                n_tests++;
                if (req_q[i] !== exp_req[i]) begin
                    n_fail++; $display("FAIL rand_req[%0d][%0d]: got %h want %h", m, i, req_q[i], exp_req[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int c;
        bit to;
        logic [31:0] pc;
        logic [108:0] obs;
        clear_sb(); cfg_ready_lat = 0; cfg_resp_lat = 2;
        miss_valid_i = 1'b1; miss_pc_i = $urandom;
        @(negedge clk);
        miss_valid_i = 1'b0;
        c = 0;
        while (wr_q.size() < 1 && c < 100) begin @(negedge clk); c++; end
        rst_n = 1'b0;
        @(negedge clk);
        obs = {miss_ready_o, busy_o, mem_req_valid_o, mem_req_addr_o, we_o, windex_o, waddr_o,
               wpcdata_o, winstdata_o, done_o, err_o};
        n_tests++;
        if (c >= 100 || obs !== {1'b1, 108'd0}) begin
            n_fail++; $display("FAIL reset_mid_outputs: got %h want %h", obs, {1'b1, 108'd0});
        end
        rst_n = 1'b1;
        for (int g = 0; g < GROUPS; g++) ptr_m[g] = 0;
        c = 0;
        while (agent_busy && c < 100) begin @(negedge clk); c++; end
        repeat (2) @(negedge clk);
        clear_sb(); cfg_resp_lat = 0;
        pc = $urandom;
        model_miss(pc, -1);
        drive_miss(pc, to);
        for (int i = 0; i < BURST; i++) begin
            n_tests++;
            if (to || i >= wr_q.size() || wr_q[i] !== exp_wr[i] || wr_q[i].way !== 3'd0) begin
                n_fail++; $display("FAIL reset_mid_ptr[%0d]: got %h want %h", i, (i < wr_q.size()) ? wr_q[i] : '0, exp_wr[i]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; miss_valid_i = 1'b0; flush_i = 1'b0; miss_pc_i = '0;
        test_reset();
        test_basic();
        test_round_robin();
        test_stall();
        test_flush();
        test_error();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
